// File: rtl/rf_cmd_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the register-file command controller.
package rf_cmd_pkg;
   localparam int         WIDTH_DEF      = 8;
   localparam int         ADDR_W_DEF     = 4;
   localparam logic [7:0] WR_CMD_DEF     = 8'hAA;
   localparam logic [7:0] RD_CMD_DEF     = 8'hBB;
   localparam int         RD_TIMEOUT_DEF = 15;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      TX_SEND
   } state_t;
endpackage

// File: rtl/rf_cmd_ctrl.sv
// UART byte-stream to register-file bridge: parses write/read frames, drives the
// register-file strobes and returns read data through the UART transmitter.
module rf_cmd_ctrl
   import rf_cmd_pkg::*;
#(
   parameter int               WIDTH      = WIDTH_DEF,
   parameter int               ADDR_W     = ADDR_W_DEF,
   parameter logic [WIDTH-1:0] WR_CMD     = WIDTH'(WR_CMD_DEF),
   parameter logic [WIDTH-1:0] RD_CMD     = WIDTH'(RD_CMD_DEF),
   parameter int               RD_TIMEOUT = RD_TIMEOUT_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  rx_data,
   input  logic              rx_valid,
   input  logic              tx_busy,
   input  logic [WIDTH-1:0]  rd_data,
   input  logic              rd_valid,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  tx_data,
   output logic              tx_valid,
   output logic              err
);

   localparam int              CNT_W    = $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic [WIDTH-1:0]  r_wr_data, w_wr_data_next;
   logic [WIDTH-1:0]  r_tx_data, w_tx_data_next;
   logic [WIDTH-1:0]  r_cap, w_cap_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic              r_wr_en, w_wr_en_next;
   logic              r_rd_en, w_rd_en_next;
   logic              r_tx_valid, w_tx_valid_next;
   logic              r_err, w_err_next;
   logic              w_addr_ok;

   assign w_addr_ok = ((rx_data >> ADDR_W) == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wr_data  <= '0;
         r_tx_data  <= '0;
         r_cap      <= '0;
         r_cnt      <= '0;
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_tx_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_addr     <= w_addr_next;
         r_wr_data  <= w_wr_data_next;
         r_tx_data  <= w_tx_data_next;
         r_cap      <= w_cap_next;
         r_cnt      <= w_cnt_next;
         r_wr_en    <= w_wr_en_next;
         r_rd_en    <= w_rd_en_next;
         r_tx_valid <= w_tx_valid_next;
         r_err      <= w_err_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_addr_next     = r_addr;
      w_wr_data_next  = r_wr_data;
      w_tx_data_next  = r_tx_data;
      w_cap_next      = r_cap;
      w_cnt_next      = r_cnt;
      w_wr_en_next    = 1'b0;
      w_rd_en_next    = 1'b0;
      w_tx_valid_next = 1'b0;
      w_err_next      = 1'b0;
      case (r_state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == WR_CMD)      w_state_next = WR_ADDR;
               else if (rx_data == RD_CMD) w_state_next = RD_ADDR;
               else                        w_err_next   = 1'b1;
            end
         end
         WR_ADDR, RD_ADDR: begin
            if (rx_valid) begin
               if (!w_addr_ok) begin
                  w_err_next   = 1'b1;
                  w_state_next = IDLE;
               end else begin
                  w_addr_next = rx_data[ADDR_W-1:0];
                  if (r_state == WR_ADDR) begin
                     w_state_next = WR_DATA;
                  end else begin
                     w_rd_en_next = 1'b1;
                     w_cnt_next   = '0;
                     w_state_next = RD_WAIT;
                  end
               end
            end
         end
         WR_DATA: begin
            if (rx_valid) begin
               w_wr_en_next   = 1'b1;
               w_wr_data_next = rx_data;
               w_state_next   = IDLE;
            end
         end
         RD_WAIT: begin
            if (rx_valid) w_err_next = 1'b1;
            // A free transmitter lets the byte leave one cycle after rd_valid,
            // skipping the TX_SEND hold state entirely.
            if (rd_valid) begin
               w_cap_next = rd_data;
               if (!tx_busy) begin
                  w_tx_valid_next = 1'b1;
                  w_tx_data_next  = rd_data;
                  w_state_next    = IDLE;
               end else begin
                  w_state_next = TX_SEND;
               end
            end else if (r_cnt == CNT_LAST) begin
               w_err_next   = 1'b1;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         TX_SEND: begin
            if (rx_valid) w_err_next = 1'b1;
            if (!tx_busy) begin
               w_tx_valid_next = 1'b1;
               w_tx_data_next  = r_cap;
               w_state_next    = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign wr_en    = r_wr_en;
   assign rd_en    = r_rd_en;
   assign addr     = r_addr;
   assign wr_data  = r_wr_data;
   assign tx_data  = r_tx_data;
   assign tx_valid = r_tx_valid;
   assign err      = r_err;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Directed bench for rf_cmd_ctrl: write/read frames, busy transmitter, protocol
// errors, read timeout (and its tie with rd_valid), and mid-frame reset.
module tb_rf_cmd_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       tx_busy = 1'b0;
   logic [7:0] rd_data = '0;
   logic       rd_valid = 1'b0;
   logic       wr_en, rd_en, tx_valid, err;
   logic [3:0] addr;
   logic [7:0] wr_data, tx_data;

   int n_vec = 0;
   int n_err = 0;
   int n_wr = 0, n_rd = 0, n_tx = 0, n_er = 0;
   bit both_seen = 1'b0;

   rf_cmd_ctrl dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_busy(tx_busy), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .err(err)
   );

   always #5 clk = ~clk;

   // Strobe pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en) n_wr++;
      if (rd_en) n_rd++;
      if (tx_valid) n_tx++;
      if (err) n_er++;
      if (wr_en && rd_en) both_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bit early;
      // Reset state
      tick(); tick();
      check("reset_outputs", {12'h0, wr_en, rd_en, tx_valid, err, addr, wr_data, tx_data}, 32'h0);
      rst = 1'b1;
      tick();

      // Write AA,05,3C
      send(8'hAA);
      send(8'h05);
      check("wr_no_early_wr_en", wr_en, 0);
      send(8'h3C);
      check("wr_wr_en", wr_en, 1);
      check("wr_addr", addr, 4'h5);
      check("wr_data", wr_data, 8'h3C);
      check("wr_no_err", err, 0);
      tick();
      check("wr_en_one_cycle", wr_en, 0);
      check("wr_addr_hold", addr, 4'h5);
      check("wr_data_hold", wr_data, 8'h3C);

      // Read BB,02 -> 81, transmitter idle
      send(8'hBB);
      send(8'h02);
      check("rd_rd_en", rd_en, 1);
      check("rd_addr", addr, 4'h2);
      check("rd_no_wr_en", wr_en, 0);
      tick();
      check("rd_en_one_cycle", rd_en, 0);
      rd_data = 8'h81; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      check("rd_tx_valid", tx_valid, 1);
      check("rd_tx_data", tx_data, 8'h81);
      tick();
      check("rd_tx_one_cycle", tx_valid, 0);
      check("rd_tx_data_hold", tx_data, 8'h81);

      // Read BB,04 -> 5A with transmitter busy ~10 cycles, stray byte meanwhile
      tx_busy = 1'b1;
      send(8'hBB);
      send(8'h04);
      tick();
      rd_data = 8'h5A; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (tx_valid) early = 1'b1;
         tick();
      end
      send(8'h11);
      check("busy_rx_err", err, 1);
      if (tx_valid) early = 1'b1;
      tick();
      if (tx_valid) early = 1'b1;
      check("busy_no_tx", early, 0);
      tx_busy = 1'b0;
      check("busy_no_tx_same_cycle", tx_valid, 0);
      tick();
      check("busy_tx_valid", tx_valid, 1);
      check("busy_tx_data", tx_data, 8'h5A);
      tick();

      // Protocol errors
      send(8'h12);
      check("bad_cmd_err", err, 1);
      tick();
      check("bad_cmd_err_pulse", err, 0);
      send(8'hAA);
      send(8'h15);
      check("bad_addr_err", err, 1);
      check("bad_addr_no_wr", wr_en, 0);
      send(8'h3C);
      check("bad_addr_back_idle_err", err, 1);
      check("bad_addr_back_idle_no_wr", wr_en, 0);
      tick();

      // Timeout BB,03 with no rd_valid
      send(8'hBB);
      send(8'h03);
      check("to_rd_en", rd_en, 1);
      for (int i = 0; i < 14; i++) tick();
      check("to_not_yet", err, 0);
      tick();
      check("to_err", err, 1);
      tick();
      check("to_err_pulse", err, 0);
      send(8'hAA);
      send(8'h01);
      send(8'hFF);
      check("to_follow_wr_en", wr_en, 1);
      check("to_follow_addr", addr, 4'h1);
      check("to_follow_data", wr_data, 8'hFF);
      tick();

      // rd_valid coinciding with the timeout cycle wins
      send(8'hBB);
      send(8'h06);
      for (int i = 0; i < 14; i++) tick();
      rd_data = 8'hC3; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      check("tie_no_err", err, 0);
      check("tie_tx_valid", tx_valid, 1);
      check("tie_tx_data", tx_data, 8'hC3);
      tick();

      // Reset mid-frame after AA,07
      send(8'hAA);
      send(8'h07);
      rst = 1'b0;
      #1;
      check("rst_outputs", {12'h0, wr_en, rd_en, tx_valid, err, addr, wr_data, tx_data}, 32'h0);
      tick();
      rst = 1'b1;
      tick();
      send(8'h55);
      check("rst_55_no_wr", wr_en, 0);
      check("rst_55_err", err, 1);
      tick(); tick();

      // Pulse totals over the whole run
      check("total_wr_en", n_wr, 2);
      check("total_rd_en", n_rd, 4);
      check("total_tx_valid", n_tx, 3);
      check("total_err", n_er, 6);
      check("never_wr_and_rd", both_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rf_cmd_ctrl.md
RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data and command byte width.
REQ-002 Parameter ADDR_W, default 4: register-file address width.
REQ-003 Parameter WR_CMD, default 8'hAA: write-frame opcode.
REQ-004 Parameter RD_CMD, default 8'hBB: read-frame opcode.
REQ-005 Parameter RD_TIMEOUT, default 15: maximum cycles to wait for rd_valid.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 rx_data  in  WIDTH  received UART byte.
REQ-009 rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-010 tx_busy  in  1  UART transmitter busy; no tx_valid accepted while high.
REQ-011 rd_data  in  WIDTH  register-file read data.
REQ-012 rd_valid  in  1  register-file read-data strobe.
REQ-013 wr_en  out  1  register-file write strobe.
REQ-014 rd_en  out  1  register-file read strobe.
REQ-015 addr  out  ADDR_W  register-file address.
REQ-016 wr_data  out  WIDTH  register-file write data.
REQ-017 tx_data  out  WIDTH  byte to transmit.
REQ-018 tx_valid  out  1  one-cycle transmit request.
REQ-019 err  out  1  one-cycle protocol-error pulse.

Function
REQ-020 Frames: write = WR_CMD, addr, data; read = RD_CMD, addr; one byte is consumed per rx_valid cycle.
REQ-021 FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
REQ-022 IDLE transitions on rx_valid: WR_CMD -> WR_ADDR; RD_CMD -> RD_ADDR; any other byte -> err pulse, remain in IDLE.
REQ-023 WR_ADDR/RD_ADDR behaviour on rx_valid: if rx_data[WIDTH-1:ADDR_W] != 0, pulse err and go to IDLE; otherwise latch rx_data[ADDR_W-1:0] into addr and advance to WR_DATA or, for a read, issue rd_en.
REQ-024 WR_DATA on rx_valid: in the next cycle, wr_en = 1 for exactly one cycle, with wr_data = the byte and addr held; then IDLE.
REQ-025 RD_ADDR accept: in the next cycle, rd_en = 1 for exactly one cycle with addr valid; state = RD_WAIT.
REQ-026 RD_WAIT: on the first rd_valid, capture rd_data and go to TX_SEND.
REQ-027 RD_WAIT timeout: a cycle counter, cleared on entry, triggers if rd_valid is absent for RD_TIMEOUT cycles; then pulse err and go to IDLE.
REQ-028 TX_SEND: in the first cycle with tx_busy = 0, tx_valid = 1 for one cycle with tx_data = the captured byte; then IDLE. Wait indefinitely while tx_busy = 1.
REQ-029 An rx_valid during RD_WAIT or TX_SEND drops the byte, pulses err, and leaves the state unchanged.
REQ-030 wr_en and rd_en are never high in the same cycle; rd_en is never reissued before the current read completes or times out.
REQ-031 All outputs are registered; no combinational path from any input to any output.
REQ-032 addr, wr_data and tx_data hold their last value between strobes.
REQ-033 If rd_valid and the timeout fall in the same cycle, rd_valid wins (no err).
REQ-034 Nominal latency: read frame's last rx_valid -> rd_en +1 cycle; regfile rd_valid +1; tx_valid +1 when tx_busy = 0.

Reset
REQ-035 On rst low: state = IDLE; wr_en, rd_en, tx_valid, err = 0; addr, wr_data, tx_data, captured data and counter = 0.
REQ-036 Reset mid-frame aborts the frame; no strobe is emitted after release until a new complete frame arrives.

Structure
REQ-037 Package rf_cmd_pkg holds WR_CMD/RD_CMD defaults, the state enum and the WIDTH/ADDR_W defaults.
REQ-038 Single module; no sub-module. The timeout counter is inline, $clog2(RD_TIMEOUT+1) bits wide.

Verification
REQ-039 Write: rx AA,05,3C -> one-cycle wr_en with addr = 5, wr_data = 8'h3C; no err.
REQ-040 Read: rx BB,02, model returns 8'h81 one cycle after rd_en, tx_busy = 0 -> tx_valid with tx_data = 8'h81 one cycle later.
REQ-041 Read with tx_busy held high for 10 cycles -> tx_valid appears exactly one cycle after tx_busy falls.
REQ-042 Errors: rx 8'h12 in IDLE -> err pulse; rx AA,8'h15 (bad addr) -> err, IDLE, no wr_en.
REQ-043 Timeout: rx BB,03 and no rd_valid -> err pulse after 15 cycles in RD_WAIT, then IDLE; a following AA,01,FF frame writes correctly.
REQ-044 Reset: assert rst after AA,07 -> all outputs 0; after release, a single 8'h55 byte produces no wr_en.
